regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Writer side of the register-file write port: merges the pipeline WB-stage write with writes
//  from a long-latency unit (mult/div) onto the single write port (wr_en/addr/data).
//  Pipeline writes have priority; long-latency results wait in a small queue.
//  Also reports whether a queried register has a write still pending, for the hazard unit.
// PARAMETERS
//  DWIDTH  `DWIDTH (32)  data width, must match register file
//  AWIDTH  `AWIDTH (5)   register address width
//  QDEPTH  2             long-latency queue entries, power of two, >=2
// PORTS
//  w_clk        in   1       clock; register file samples our outputs on the following negedge
//  w_rst        in   1       asynchronous active-low reset
//  w_wb_valid   in   1       pipeline WB write request; always accepted, no ready
//  w_wb_addr    in   AWIDTH  pipeline destination register
//  w_wb_data    in   DWIDTH  pipeline result
//  w_lu_valid   in   1       long-latency result valid
//  w_lu_ready   out  1       queue can accept; transfer when valid&&ready at posedge
//  w_lu_addr    in   AWIDTH  long-latency destination register
//  w_lu_data    in   DWIDTH  long-latency result
//  w_wr_en      out  1       to register file write enable
//  w_wr_addr    out  AWIDTH  to register file write address
//  w_wr_data    out  DWIDTH  to register file write data
//  w_chk_addr   in   AWIDTH  register number queried by hazard unit
//  w_chk_hit    out  1       1 = w_chk_addr matches a queued entry or the current w_wr_* write
// BEHAVIOUR
//  - Reset (async, w_rst=0): w_wr_en=0, w_wr_addr=0, w_wr_data=0, queue emptied, w_lu_ready=1
//    after release; reset mid-operation discards all queued entries, nothing is written.
//  - w_wr_en/addr/data are registered: request sampled at posedge N appears after posedge N,
//    register file commits it at the negedge inside cycle N+1 (one-cycle latency).
//  - Per posedge, output source chosen in priority: (1) w_wb_valid with w_wb_addr!=0;
//    (2) queue head if queue non-empty (pop it); (3) idle: w_wr_en=0, addr/data hold last values.
//  - Writes to register 0 are dropped at input: WB one produces no write; LU one is accepted
//    (handshake completes) but not queued.
//  - w_lu_ready = (count < QDEPTH), from registered count only; at full, ready stays 0 in a
//    cycle that pops (no same-cycle push-through at full).
//  - Push and pop in the same cycle when not full: count unchanged, FIFO order kept.
//  - Empty queue + LU push + no WB write: entry enters queue, emerges on w_wr_* one cycle later
//    (no bypass); total LU latency 2 cycles minimum.
//  - Queue pointers wrap modulo QDEPTH; count is clog2(QDEPTH)+1 bits, 0..QDEPTH.
//  - Ordering: WB and queued writes to the same register are not reordered against each other;
//    hazard unit must stall while w_chk_hit=1. w_chk_hit is combinational from queue contents
//    and w_wr_en/w_wr_addr; w_chk_addr=0 always gives 0.
//  - WB writes can starve the queue indefinitely; the pipeline stalls on w_lu_ready=0.
// STRUCTURE
//  - DWIDTH/AWIDTH defaults from header.vh macros; no new shared constants needed.
//  - One sub-module: wb_queue (QDEPTH x (AWIDTH+DWIDTH) FIFO with push/pop/count, async reset,
//    per-entry valid+addr outputs for the hit compare). Arbitration and hit logic stay in top.
// TESTING
//  1 WB only: wb_valid=1 addr=5 data=0xDEAD_BEEF -> next cycle wr_en=1 addr=5 data=0xDEADBEEF.
//  2 Priority: WB addr=3 and LU addr=7 same cycle -> cycle+1 writes r3, cycle+2 writes r7.
//  3 Full: WB busy every cycle, LU pushes r8,r9 -> ready=0; WB stops -> r8 then r9 in order,
//    ready=1 after first pop.
//  4 Zero reg: WB addr=0 -> wr_en stays 0; LU addr=0 accepted, count stays 0, no write.
//  5 Hazard: queue holds r12 -> chk_addr=12 gives hit=1, chk_addr=13 gives 0; hit clears
//    the cycle after r12 leaves w_wr_*.
//  6 Reset mid-op: 2 entries queued, w_rst low for 1 cycle -> wr_en=0, ready=1, no later writes.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared defaults and types for the register-file write arbiter slice.
package regfile_write_arbiter_pkg;

  localparam int unsigned DEF_DWIDTH = 32;
  localparam int unsigned DEF_AWIDTH = 5;
  localparam int unsigned DEF_QDEPTH = 2;

  // Source feeding the write port on the next cycle.
  typedef enum logic [1:0] {
    SRC_IDLE,
    SRC_WB,
    SRC_LU
  } wr_src_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writer-side bus: pipeline WB request, long-latency handshake, write port, hazard query.
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DWIDTH = DEF_DWIDTH,
  parameter int unsigned AWIDTH = DEF_AWIDTH
);

  logic              w_wb_valid;
  logic [AWIDTH-1:0] w_wb_addr;
  logic [DWIDTH-1:0] w_wb_data;
  logic              w_lu_valid;
  logic              w_lu_ready;
  logic [AWIDTH-1:0] w_lu_addr;
  logic [DWIDTH-1:0] w_lu_data;
  logic              w_wr_en;
  logic [AWIDTH-1:0] w_wr_addr;
  logic [DWIDTH-1:0] w_wr_data;
  logic [AWIDTH-1:0] w_chk_addr;
  logic              w_chk_hit;

  // Requesters and consumers of the write port.
  modport master (
    output w_wb_valid, w_wb_addr, w_wb_data,
    output w_lu_valid, w_lu_addr, w_lu_data,
    output w_chk_addr,
    input  w_lu_ready, w_wr_en, w_wr_addr, w_wr_data, w_chk_hit
  );

  // The arbiter itself.
  modport slave (
    input  w_wb_valid, w_wb_addr, w_wb_data,
    input  w_lu_valid, w_lu_addr, w_lu_data,
    input  w_chk_addr,
    output w_lu_ready, w_wr_en, w_wr_addr, w_wr_data, w_chk_hit
  );

endinterface

// File: rtl/regfile_write_arbiter_wb_queue.sv
// Small FIFO holding long-latency writes; exposes per-entry valid/addr for hazard compare.
module wb_queue #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned QDEPTH = 2,
  localparam int unsigned PW    = $clog2(QDEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [AWIDTH-1:0]             push_addr,
  input  logic [DWIDTH-1:0]             push_data,
  input  logic                          pop,
  output logic [AWIDTH-1:0]             head_addr,
  output logic [DWIDTH-1:0]             head_data,
  output logic [CW-1:0]                 count,
  output logic [QDEPTH-1:0]             ent_valid,
  output logic [QDEPTH-1:0][AWIDTH-1:0] ent_addr
);

  logic [QDEPTH-1:0][AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0]             data_q [QDEPTH];
  logic [QDEPTH-1:0]             valid_q;
  logic [PW-1:0]                 wr_ptr;
  logic [PW-1:0]                 rd_ptr;
  logic [CW-1:0]                 count_q;

  // Storage, pointers and occupancy; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) data_q[i] <= '0;
      valid_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      // Push and pop never target the same slot: pop needs non-empty, push needs non-full.
      if (push) begin
        addr_q[wr_ptr]  <= push_addr;
        data_q[wr_ptr]  <= push_data;
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      if (push && !pop) count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign count     = count_q;
  assign ent_valid = valid_q;
  assign ent_addr  = addr_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges pipeline WB writes with queued long-latency results onto one register-file write port.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DWIDTH = DEF_DWIDTH,
  parameter int unsigned AWIDTH = DEF_AWIDTH,
  parameter int unsigned QDEPTH = DEF_QDEPTH,
  localparam int unsigned CW    = $clog2(QDEPTH) + 1
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  regfile_write_arbiter_if.slave bus
);

  logic [AWIDTH-1:0]             head_addr;
  logic [DWIDTH-1:0]             head_data;
  logic [CW-1:0]                 q_count;
  logic [QDEPTH-1:0]             ent_valid;
  logic [QDEPTH-1:0][AWIDTH-1:0] ent_addr;

  logic    lu_ready;
  logic    q_push;
  logic    q_pop;
  wr_src_e src;
  logic    hit;

  logic              wr_en_q;
  logic [AWIDTH-1:0] wr_addr_q;
  logic [DWIDTH-1:0] wr_data_q;

  wb_queue #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH),
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk       (w_clk),
    .rst_n     (w_rst),
    .push      (q_push),
    .push_addr (bus.w_lu_addr),
    .push_data (bus.w_lu_data),
    .pop       (q_pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (q_count),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr)
  );

  // Arbitration: live WB write first, then queue head; r0 writes are swallowed at the input.
  always_comb begin
    lu_ready = q_count < CW'(QDEPTH);
    q_push   = bus.w_lu_valid && lu_ready && (bus.w_lu_addr != '0);
    src      = SRC_IDLE;
    if (bus.w_wb_valid && (bus.w_wb_addr != '0)) src = SRC_WB;
    else if (q_count != '0)                      src = SRC_LU;
    q_pop    = (src == SRC_LU);
  end

  // Registered write port; addr/data hold their last values while idle.
  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (src)
        SRC_WB: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= bus.w_wb_addr;
          wr_data_q <= bus.w_wb_data;
        end
        SRC_LU: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= head_addr;
          wr_data_q <= head_data;
        end
        default: wr_en_q <= 1'b0;
      endcase
    end
  end

  // Pending-write lookup for the hazard unit: any queued entry or the write now on the port.
  always_comb begin
    hit = 1'b0;
    if (bus.w_chk_addr != '0) begin
      if (wr_en_q && (wr_addr_q == bus.w_chk_addr)) hit = 1'b1;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        if (ent_valid[i] && (ent_addr[i] == bus.w_chk_addr)) hit = 1'b1;
      end
    end
  end

  assign bus.w_lu_ready = lu_ready;
  assign bus.w_chk_hit  = hit;
  assign bus.w_wr_en    = wr_en_q;
  assign bus.w_wr_addr  = wr_addr_q;
  assign bus.w_wr_data  = wr_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed plus random checks of the write arbiter against a queue-based reference model.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  localparam int unsigned DW = DEF_DWIDTH;
  localparam int unsigned AW = DEF_AWIDTH;
  localparam int unsigned QD = DEF_QDEPTH;

  logic clk = 1'b0;
  logic rst = 1'b0;

  regfile_write_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  regfile_write_arbiter #(
    .DWIDTH(DW),
    .AWIDTH(AW),
    .QDEPTH(QD)
  ) dut (
    .w_clk (clk),
    .w_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  // Reference model: pending writes in arrival order plus the value on the write port.
  wr_t           mq[$];
  logic          m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_hit(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (m_en && m_addr == a) return 1'b1;
    foreach (mq[i]) if (mq[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_en   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic drive(input logic wbv, input logic [AW-1:0] wba, input logic [DW-1:0] wbd,
                       input logic luv, input logic [AW-1:0] lua, input logic [DW-1:0] lud,
                       input logic [AW-1:0] chk);
    bus.w_wb_valid = wbv;
    bus.w_wb_addr  = wba;
    bus.w_wb_data  = wbd;
    bus.w_lu_valid = luv;
    bus.w_lu_addr  = lua;
    bus.w_lu_data  = lud;
    bus.w_chk_addr = chk;
  endtask

  // One clock: check combinational outputs, advance model, check the registered write port.
  task automatic step(input string tag);
    logic ready;
    wr_t  e;
    #2;
    ready = (mq.size() < QD);
    check({tag, " ready"}, 64'(bus.w_lu_ready), 64'(ready));
    check({tag, " hit"}, 64'(bus.w_chk_hit), 64'(m_hit(bus.w_chk_addr)));
    if (bus.w_wb_valid && bus.w_wb_addr != 0) begin
      m_en   = 1'b1;
      m_addr = bus.w_wb_addr;
      m_data = bus.w_wb_data;
    end else if (mq.size() > 0) begin
      e      = mq.pop_front();
      m_en   = 1'b1;
      m_addr = e.addr;
      m_data = e.data;
    end else begin
      m_en = 1'b0;
    end
    if (bus.w_lu_valid && ready && bus.w_lu_addr != 0) begin
      e.addr = bus.w_lu_addr;
      e.data = bus.w_lu_data;
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
    check({tag, " wr_en"}, 64'(bus.w_wr_en), 64'(m_en));
    check({tag, " wr_addr"}, 64'(bus.w_wr_addr), 64'(m_addr));
    check({tag, " wr_data"}, 64'(bus.w_wr_data), 64'(m_data));
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    m_reset();
    #1;
    check("reset wr_en", 64'(bus.w_wr_en), 64'd0);
    check("reset wr_addr", 64'(bus.w_wr_addr), 64'd0);
    check("reset wr_data", 64'(bus.w_wr_data), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("release ready", 64'(bus.w_lu_ready), 64'd1);

    // WB only
    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
    step("t1");
    check("t1 data", 64'(bus.w_wr_data), 64'hDEAD_BEEF);
    drive(0, 0, 0, 0, 0, 0, 0);
    step("t1 idle");

    // Priority: WB r3 and LU r7 in the same cycle
    drive(1, 3, 32'h0000_0333, 1, 7, 32'h0000_0777, 0);
    step("t2 a");
    check("t2 first", 64'(bus.w_wr_addr), 64'd3);
    drive(0, 0, 0, 0, 0, 0, 0);
    step("t2 b");
    check("t2 second", 64'(bus.w_wr_addr), 64'd7);
    step("t2 c");

    // Full queue under continuous WB traffic
    drive(1, 1, 32'h11, 1, 8, 32'h88, 0);
    step("t3 push8");
    drive(1, 2, 32'h22, 1, 9, 32'h99, 0);
    step("t3 push9");
    drive(1, 4, 32'h44, 1, 10, 32'hAA, 0);
    #1;
    check("t3 full ready", 64'(bus.w_lu_ready), 64'd0);
    step("t3 full");
    drive(0, 0, 0, 0, 0, 0, 0);
    step("t3 pop8");
    check("t3 r8", 64'(bus.w_wr_addr), 64'd8);
    step("t3 pop9");
    check("t3 r9", 64'(bus.w_wr_addr), 64'd9);
    step("t3 idle");

    // Register zero
    drive(1, 0, 32'h1234, 1, 0, 32'h5678, 0);
    step("t4 zero");
    check("t4 no write", 64'(bus.w_wr_en), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    step("t4 idle");

    // Hazard lookup while r12 waits behind WB traffic
    drive(1, 6, 32'h66, 1, 12, 32'hC0C0, 12);
    step("t5 push12");
    drive(1, 6, 32'h67, 0, 0, 0, 12);
    #1;
    check("t5 hit12", 64'(bus.w_chk_hit), 64'd1);
    step("t5 q12");
    drive(1, 6, 32'h68, 0, 0, 0, 13);
    #1;
    check("t5 miss13", 64'(bus.w_chk_hit), 64'd0);
    step("t5 q13");
    drive(0, 0, 0, 0, 0, 0, 12);
    step("t5 pop12");
    step("t5 port12");
    step("t5 clear");
    check("t5 cleared", 64'(bus.w_chk_hit), 64'd0);

    // Reset with two entries queued
    drive(1, 1, 32'h1, 1, 14, 32'hE, 0);
    step("t6 q14");
    drive(1, 2, 32'h2, 1, 15, 32'hF, 0);
    step("t6 q15");
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    m_reset();
    check("t6 rst wr_en", 64'(bus.w_wr_en), 64'd0);
    check("t6 rst wr_addr", 64'(bus.w_wr_addr), 64'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t6 ready", 64'(bus.w_lu_ready), 64'd1);
    repeat (3) step("t6 after");

    // Random traffic with a narrow address range to provoke hits and collisions
    repeat (400) begin
      drive(1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)), DW'($urandom()),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom()),
            AW'($urandom_range(0, 7)));
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
